// File: rtl/ft601_bus_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft601_model_pkg
// Description : Shared widths, byte-enable constant and source-state encoding
//               for the FT601 245-sync-FIFO device model.
// Revision    : 1.0 - initial release
// ============================================================================
package ft601_model_pkg;

    localparam int                 FT_DATA_W = 32;
    localparam int                 FT_BE_W   = 4;
    localparam logic [FT_BE_W-1:0] FT_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        SRC_WAIT_START = 2'd0,
        SRC_OFFER      = 2'd1,
        SRC_GAP        = 2'd2
    } src_state_e;

endpackage
`default_nettype wire

// File: rtl/ft601_bus_model_if.sv
`default_nettype none
// ============================================================================
// Module      : ft601_bus_model_if
// Description : FT601 handshake strobes and flags (DATA/BE stay on the top).
// Revision    : 1.0 - initial release
// ============================================================================
interface ft601_bus_model_if;

    logic TXE_N;
    logic RXF_N;
    logic WR_N;
    logic RD_N;
    logic OE_N;
    logic SIWU_N;

    // master = FPGA side, slave = device model side
    modport master (
        input  TXE_N, RXF_N,
        output WR_N, RD_N, OE_N, SIWU_N
    );

    modport slave (
        output TXE_N, RXF_N,
        input  WR_N, RD_N, OE_N, SIWU_N
    );

endinterface
`default_nettype wire

// File: rtl/ft601_bus_model_src_gen.sv
`default_nettype none
// ============================================================================
// Module      : ft601_src_gen
// Description : Host-to-FPGA word source: incrementing pattern, burst/gap
//               counters and registered RXF_N.
// Revision    : 1.0 - initial release
// ============================================================================
module ft601_src_gen
    import ft601_model_pkg::*;
#(
    parameter int                   PKT_WORDS    = 16,
    parameter int                   PKT_GAP      = 4,
    parameter logic [FT_DATA_W-1:0] PATTERN_SEED = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_go,
    input  logic                 rd_xfer,
    output logic                 rxf_n,
    output logic [FT_DATA_W-1:0] src_word
);

    localparam logic [1:0] ST_WAIT_START = SRC_WAIT_START;
    localparam logic [1:0] ST_OFFER      = SRC_OFFER;
    localparam logic [1:0] ST_GAP        = SRC_GAP;

    localparam int BURST_W = $clog2(PKT_WORDS + 1);
    localparam int GAP_W   = $clog2(PKT_GAP + 1);
    localparam logic [BURST_W-1:0] C_BURST_LAST = BURST_W'(PKT_WORDS - 1);
    localparam logic [GAP_W-1:0]   C_GAP_LAST   = GAP_W'(PKT_GAP - 1);

    logic [1:0]           r_state;
    logic [BURST_W-1:0]   r_burst_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic                 r_rxf_n;
    logic [FT_DATA_W-1:0] r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT_START;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_rxf_n     <= 1'b1;
            r_word      <= PATTERN_SEED;
        end else begin
            case (r_state)
                ST_WAIT_START: begin
                    if (start_go) begin
                        r_state <= ST_OFFER;
                        r_rxf_n <= 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (rd_xfer) begin
                        r_word <= r_word + 32'd1;
                        // the edge that moves the last word of a burst closes the offer
                        if (r_burst_cnt == C_BURST_LAST) begin
                            r_state   <= ST_GAP;
                            r_rxf_n   <= 1'b1;
                            r_gap_cnt <= '0;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == C_GAP_LAST) begin
                        r_state     <= ST_OFFER;
                        r_rxf_n     <= 1'b0;
                        r_burst_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_START;
                    r_rxf_n <= 1'b1;
                end
            endcase
        end
    end

    assign rxf_n    = r_rxf_n;
    assign src_word = r_word;

endmodule
`default_nettype wire

// File: rtl/ft601_bus_model.sv
`default_nettype none
// ============================================================================
// Module      : ft601_bus_model
// Description : Cycle-accurate FT601 245 sync-FIFO device model (32-bit bus):
//               sources a pattern stream, sinks writes with finite buffering.
//               Optional write-pattern checker: define FT601_MODEL_TXCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ft601_bus_model
    import ft601_model_pkg::*;
#(
    parameter int                   PKT_WORDS      = 16,
    parameter int                   PKT_GAP        = 4,
    parameter int                   SINK_DEPTH     = 64,
    parameter int                   DRAIN_INTERVAL = 4,
    parameter int                   START_DELAY    = 8,
    parameter logic [FT_DATA_W-1:0] PATTERN_SEED   = 32'h0000_0000
) (
    input  logic                  ft601_clk,
    input  logic                  reset_n,
    ft601_bus_model_if.slave      bus,
    inout  wire  [FT_BE_W-1:0]    BE,
    inout  wire  [FT_DATA_W-1:0]  DATA,
    output logic [31:0]           rx_words,
    output logic [31:0]           tx_words,
    output logic [FT_DATA_W-1:0]  last_tx_data,
    output logic                  proto_err,
    output logic                  chk_err
);

    localparam int START_W = $clog2(START_DELAY + 1);
    localparam int OCC_W   = $clog2(SINK_DEPTH + 1);
    localparam int DRAIN_W = $clog2(DRAIN_INTERVAL + 1);
    localparam logic [START_W-1:0] C_START_LAST = START_W'(START_DELAY - 1);
    localparam logic [OCC_W-1:0]   C_DEPTH      = OCC_W'(SINK_DEPTH);
    localparam logic [DRAIN_W-1:0] C_DRAIN_LAST = DRAIN_W'(DRAIN_INTERVAL - 1);

    logic [START_W-1:0]   r_start_cnt;
    logic                 r_started;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_txe_n;
    logic [31:0]          r_rx_words;
    logic [31:0]          r_tx_words;
    logic [FT_DATA_W-1:0] r_last_tx;
    logic                 r_proto_err;

    logic                 w_start_go;
    logic                 w_rxf_n;
    logic [FT_DATA_W-1:0] w_src_word;
    logic                 w_rd_xfer;
    logic                 w_wr_xfer;
    logic                 w_drain;
    logic                 w_violation;
    logic [OCC_W-1:0]     w_occ_next;
    logic                 w_unused;

    assign w_start_go = !r_started && (r_start_cnt == C_START_LAST);

    ft601_src_gen #(
        .PKT_WORDS    (PKT_WORDS),
        .PKT_GAP      (PKT_GAP),
        .PATTERN_SEED (PATTERN_SEED)
    ) u_src_gen (
        .clk      (ft601_clk),
        .rst_n    (reset_n),
        .start_go (w_start_go),
        .rd_xfer  (w_rd_xfer),
        .rxf_n    (w_rxf_n),
        .src_word (w_src_word)
    );

    assign w_rd_xfer = !w_rxf_n && !bus.OE_N && !bus.RD_N;
    assign w_wr_xfer = !r_txe_n && !bus.WR_N && bus.OE_N;
    assign w_drain   = (r_drain_cnt == C_DRAIN_LAST) && (r_occ != '0);

    assign w_violation = (!bus.RD_N && (w_rxf_n || bus.OE_N)) ||
                         (!bus.WR_N && r_txe_n) ||
                         (!bus.WR_N && !bus.OE_N);

    always_comb begin
        w_occ_next = r_occ;
        if (w_wr_xfer && !w_drain) begin
            w_occ_next = r_occ + 1'b1;
        end else if (!w_wr_xfer && w_drain) begin
            w_occ_next = r_occ - 1'b1;
        end
    end

    always_ff @(posedge ft601_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_cnt <= '0;
            r_started   <= 1'b0;
            r_drain_cnt <= '0;
            r_occ       <= '0;
            r_txe_n     <= 1'b1;
            r_rx_words  <= '0;
            r_tx_words  <= '0;
            r_last_tx   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (!r_started) begin
                r_start_cnt <= r_start_cnt + 1'b1;
            end
            if (w_start_go) begin
                r_started <= 1'b1;
            end

            r_drain_cnt <= (r_drain_cnt == C_DRAIN_LAST) ? '0 : r_drain_cnt + 1'b1;
            r_occ       <= w_occ_next;

            // TXE_N looks one cycle ahead so a write that fills the sink is the last one
            if (r_started || w_start_go) begin
                r_txe_n <= (w_occ_next >= C_DEPTH);
            end

            if (w_rd_xfer) begin
                r_rx_words <= r_rx_words + 32'd1;
            end
            if (w_wr_xfer) begin
                r_tx_words <= r_tx_words + 32'd1;
                r_last_tx  <= DATA;
            end
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

`ifdef FT601_MODEL_TXCHK_EN
    logic r_chk_err;

    // word k of the write stream is expected to be PATTERN_SEED + k
    always_ff @(posedge ft601_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chk_err <= 1'b0;
        end else if (w_wr_xfer && (DATA != (PATTERN_SEED + r_tx_words))) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

    assign DATA = bus.OE_N ? {FT_DATA_W{1'bz}} : w_src_word;
    assign BE   = bus.OE_N ? {FT_BE_W{1'bz}}   : FT_BE_ALL;

    assign bus.TXE_N  = r_txe_n;
    assign bus.RXF_N  = w_rxf_n;
    assign rx_words     = r_rx_words;
    assign tx_words     = r_tx_words;
    assign last_tx_data = r_last_tx;
    assign proto_err    = r_proto_err;

    assign w_unused = &{1'b0, bus.SIWU_N, BE};

endmodule
`default_nettype wire

// File: tb/tb_ft601_bus_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft601_bus_model
// Description : Directed self-checking bench for the FT601 device model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ft601_bus_model;

`ifdef FT601_MODEL_TXCHK_EN
    localparam bit TXCHK = 1'b1;
`else
    localparam bit TXCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        drv;
    logic [31:0] drv_data;
    wire  [31:0] data_bus;
    wire  [3:0]  be_bus;
    logic [31:0] rx_words;
    logic [31:0] tx_words;
    logic [31:0] last_tx_data;
    logic        proto_err;
    logic        chk_err;

    int n_checks = 0;
    int n_errors = 0;
    int edge_no  = 0;
    int occ;
    int n_acc;
    bit full_seen;
    bit resumed;
    bit wr;
    bit drn;

    ft601_bus_model_if bus_if();

    assign data_bus = drv ? drv_data : {32{1'bz}};
    assign be_bus   = drv ? 4'hF : 4'hz;

    ft601_bus_model dut (
        .ft601_clk    (clk),
        .reset_n      (reset_n),
        .bus          (bus_if),
        .BE           (be_bus),
        .DATA         (data_bus),
        .rx_words     (rx_words),
        .tx_words     (tx_words),
        .last_tx_data (last_tx_data),
        .proto_err    (proto_err),
        .chk_err      (chk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) edge_no = 0;
        else          edge_no = edge_no + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic do_write(input logic [31:0] v);
        drv = 1'b1;
        drv_data = v;
        bus_if.WR_N = 1'b0;
        tick();
        bus_if.WR_N = 1'b1;
        drv = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        drv           = 1'b0;
        drv_data      = '0;
        bus_if.WR_N   = 1'b1;
        bus_if.RD_N   = 1'b1;
        bus_if.OE_N   = 1'b1;
        bus_if.SIWU_N = 1'b1;
        tick();
        tick();

        check_val("rst_rxf",   bus_if.RXF_N, 1);
        check_val("rst_txe",   bus_if.TXE_N, 1);
        check_val("rst_rx",    rx_words, 0);
        check_val("rst_tx",    tx_words, 0);
        check_val("rst_last",  last_tx_data, 0);
        check_val("rst_proto", proto_err, 0);
        check_val("rst_chk",   chk_err, 0);

        // startup: flags assert on the 8th edge after release
        reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val("start_rxf", bus_if.RXF_N, (i >= 8) ? 0 : 1);
            check_val("start_txe", bus_if.TXE_N, (i >= 8) ? 0 : 1);
        end

        // read burst: OE_N first, RD_N one cycle later
        bus_if.OE_N = 1'b0;
        #1;
        check_val("data_oe", data_bus, 32'h0);
        tick();
        bus_if.RD_N = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            check_val("rd_data", data_bus, k);
            tick();
        end
        bus_if.RD_N = 1'b1;
        check_val("rd_count", rx_words, 16);
        check_val("rd_rxf_hi", bus_if.RXF_N, 1);
        check_val("rd_next", data_bus, 32'h10);
        for (int g = 1; g <= 4; g++) begin
            tick();
            check_val("gap_rxf", bus_if.RXF_N, (g == 4) ? 0 : 1);
        end
        bus_if.RD_N = 1'b0;
        #1;
        check_val("rd2_data", data_bus, 32'h10);
        tick();
        bus_if.RD_N = 1'b1;
        check_val("rd2_count", rx_words, 17);
        check_val("rd2_next", data_bus, 32'h11);
        bus_if.OE_N = 1'b1;
        tick();

        // write fill; drain fires on edges numbered multiple of 4 since release
        occ = 0;
        n_acc = 0;
        full_seen = 1'b0;
        drv = 1'b1;
        for (int c = 0; c < 300 && !full_seen; c++) begin
            wr = (bus_if.TXE_N == 1'b0);
            bus_if.WR_N = !wr;
            drv_data = n_acc;
            tick();
            drn = ((edge_no % 4) == 0) && (occ != 0);
            if (wr) n_acc++;
            if (wr && !drn) occ++;
            else if (!wr && drn) occ--;
            check_val("fill_txe", bus_if.TXE_N, (occ >= 64) ? 1 : 0);
            if (bus_if.TXE_N) full_seen = 1'b1;
        end
        bus_if.WR_N = 1'b1;
        drv = 1'b0;
        check_val("fill_full", full_seen, 1);
        check_val("fill_tx", tx_words, n_acc);
        check_val("fill_last", last_tx_data, n_acc - 1);
        check_val("fill_proto", proto_err, 0);
        check_val("fill_chk", chk_err, 0);

        resumed = 1'b0;
        for (int c = 0; c < 5 && !resumed; c++) begin
            tick();
            if (!bus_if.TXE_N) resumed = 1'b1;
        end
        check_val("resume_txe", resumed, 1);
        check_val("resume_proto", proto_err, 0);

        // read strobe with OE_N high
        bus_if.RD_N = 1'b0;
        tick();
        bus_if.RD_N = 1'b1;
        check_val("viol_rd_proto", proto_err, 1);
        check_val("viol_rd_rx", rx_words, 17);

        // asynchronous reset mid-stream
        reset_n = 1'b0;
        #1;
        check_val("arst_proto", proto_err, 0);
        check_val("arst_rx", rx_words, 0);
        check_val("arst_rxf", bus_if.RXF_N, 1);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check_val("rst2_rxf", bus_if.RXF_N, 0);
        bus_if.OE_N = 1'b0;
        #1;
        check_val("rst2_seed", data_bus, 32'h0);

        // write strobe while OE_N low
        bus_if.WR_N = 1'b0;
        tick();
        bus_if.WR_N = 1'b1;
        bus_if.OE_N = 1'b1;
        check_val("viol_wr_proto", proto_err, 1);
        check_val("viol_wr_tx", tx_words, 0);

        // pattern-matching write stream
        restart();
        for (int k = 0; k < 4; k++) do_write(k);
        check_val("chk_good_tx", tx_words, 4);
        check_val("chk_good", chk_err, 0);

        restart();
        do_write(0);
        do_write(1);
        do_write(2);
        check_val("chk_pre", chk_err, 0);
        do_write(5);
        check_val("chk_bad_tx", tx_words, 4);
        check_val("chk_bad_last", last_tx_data, 5);
        check_val("chk_bad", chk_err, TXCHK ? 1 : 0);
        check_val("chk_proto", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
